feature_map_to_rgb565: RTL and testbench

FEATURE_MAP_TO_RGB565 -- requirements
Module: feature_map_to_rgb565

---
 rtl/feature_map_to_rgb565.sv | 95 +++++++++
 tb/tb_feature_map_to_rgb565.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/feature_map_to_rgb565.sv
// feature_map_to_rgb565: converts BFLOAT16 RGB feature values to RGB565 via one shared converter
module feature_map_to_rgb565 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_r,
  input  logic [15:0]      in_g,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_pixel,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);
  typedef enum logic [2:0] {IDLE, CONV_R, CONV_G, CONV_B, OUT} state_t;
  state_t state, state_nx;
  logic live, sat_q, special, is_nan, zero, big, clamp, ch_sat;
  logic [15:0] r_q, g_q, b_q, x;
  logic [4:0] r_f, b_f;
  logic [5:0] g_f, lim, val;
  logic [7:0] e, sh, raw;
  // shared converter: n = floor(x*64), i.e. {1,m} >> (128-e), clamped to the channel width
  always_comb begin
    x = state == CONV_R ? r_q : state == CONV_G ? g_q : b_q;
    e = x[14:7];
    special = e == 8'hFF;
    is_nan = special && x[6:0] != 7'd0;
    zero = x[15] || e < 8'd121 || is_nan;
    big = e >= 8'd127;
    sh = 8'd128 - e;
    raw = {1'b1, x[6:0]} >> sh;
    lim = state == CONV_G ? 6'd63 : 6'd31;
    clamp = big || raw > {2'b00, lim};
    val = zero ? 6'd0 : clamp ? lim : raw[5:0];
    ch_sat = special || (!zero && clamp);
  end
  // next-state logic and handshake outputs
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE   ? (in_valid && in_ready ? CONV_R : IDLE) :
               state == CONV_R ? CONV_G :
               state == CONV_G ? CONV_B :
               state == CONV_B ? OUT :
               (out_ready ? IDLE : OUT);
    in_ready = live && state == IDLE;
    out_valid = state == OUT;
    out_pixel = {r_f, g_f, b_f};
    out_sat = sat_q;
  end
  // state register; live holds in_ready low until the first edge after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      live <= 1'b0;
    end else begin
      state <= state_nx;
      live <= 1'b1;
    end
  end
  // capture inputs, store one converted field per CONV cycle, count delivered pixels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      r_f <= '0;
      g_f <= '0;
      b_f <= '0;
      sat_q <= 1'b0;
      out_count <= '0;
    end else begin
      if (in_valid && in_ready) begin
        r_q <= in_r;
        g_q <= in_g;
        b_q <= in_b;
      end
      if (state == CONV_R) begin
        r_f <= val[4:0];
        sat_q <= ch_sat;
      end
      if (state == CONV_G) begin
        g_f <= val;
        sat_q <= sat_q || ch_sat;
      end
      if (state == CONV_B) begin
        b_f <= val[4:0];
        sat_q <= sat_q || ch_sat;
      end
      if (out_valid && out_ready) out_count <= out_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_feature_map_to_rgb565.sv
// tb_feature_map_to_rgb565: directed-vector self-checking bench for feature_map_to_rgb565
module tb_feature_map_to_rgb565;
  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] in_r = '0, in_g = '0, in_b = '0;
  logic in_ready, out_valid, out_sat, in_ready4, out_valid4, out_sat4;
  logic [15:0] out_pixel, out_pixel4;
  logic [15:0] out_count;
  logic [3:0] out_count4;
  int checks = 0, errors = 0;

  feature_map_to_rgb565 dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_sat(out_sat), .out_count(out_count)
  );

  feature_map_to_rgb565 #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .out_valid(out_valid4), .out_ready(out_ready),
    .out_pixel(out_pixel4), .out_sat(out_sat4), .out_count(out_count4)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready", in_ready, 1);
    in_r = r;
    in_g = g;
    in_b = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pixel(input string tag, input logic [15:0] r, input logic [15:0] g,
                       input logic [15:0] b, input logic [15:0] ep, input logic es);
    int n = 0;
    send(r, g, b);
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 3);
    chk({tag, "_pix"}, out_pixel, ep);
    chk({tag, "_sat"}, out_sat, es);
  endtask

  initial begin
    #2;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pix", out_pixel, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_cnt", out_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("first_ready", in_ready, 1);

    pixel("norm", 16'h3EF8, 16'h3F7C, 16'h3C80, 16'hFFE1, 1'b0);
    step();
    chk("norm_cnt", out_count, 1);
    chk("norm_done", out_valid, 0);
    pixel("satv", 16'h3F80, 16'hBF00, 16'h7FC0, 16'hF800, 1'b1);
    step();
    chk("satv_cnt", out_count, 2);
    pixel("small", 16'h0000, 16'h0040, 16'h3C7F, 16'h0000, 1'b0);
    step();
    pixel("half", 16'h0000, 16'h3F00, 16'h0000, 16'h0400, 1'b0);
    step();
    pixel("inf", 16'h7F80, 16'h0000, 16'h3F7C, 16'hF81F, 1'b1);
    step();
    chk("inf_cnt", out_count, 5);

    out_ready = 1'b0;
    pixel("bp", 16'h3EF8, 16'h3F7C, 16'h3C80, 16'hFFE1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_r = 16'h3F80;
      in_g = 16'h0000;
      in_b = 16'h7F80;
      step();
      chk("bp_pix", out_pixel, 16'hFFE1);
      chk("bp_sat", out_sat, 0);
      chk("bp_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_done", out_valid, 0);
    chk("bp_idle", in_ready, 1);
    chk("bp_cnt", out_count, 6);

    send(16'h3F80, 16'h3F80, 16'h3F80);
    step();
    reset_n = 1'b0;
    #1;
    chk("mid_valid", out_valid, 0);
    chk("mid_ready", in_ready, 0);
    chk("mid_pix", out_pixel, 0);
    chk("mid_sat", out_sat, 0);
    chk("mid_cnt", out_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pixel("post", 16'h3EF8, 16'h3F7C, 16'h3C80, 16'hFFE1, 1'b0);
    step();
    chk("post_cnt", out_count, 1);

    reset_n = 1'b0;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      pixel("wrap", 16'h3EF8, 16'h3F7C, 16'h3C80, 16'hFFE1, 1'b0);
      step();
      if (i == 16) chk("wrap16", out_count4, 0);
      if (i == 17) chk("wrap17", out_count4, 1);
    end
    chk("cnt17", out_count, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
